// File: rtl/k_dsp_alu_mc_if.sv
// Command/result bundle for the K_DSP multi-cycle ALU.
// The slave side is the ALU; the master side is the producer/consumer.
interface k_dsp_alu_mc_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_dbz;
    logic             wr_en;

    modport slave (
        input  in_valid, op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_dbz, wr_en
    );

    modport master (
        output in_valid, op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_dbz, wr_en
    );
endinterface

// File: rtl/k_dsp_alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle arithmetic/logic ops plus a restoring
// divider (one quotient bit per clock) for quotient and remainder.
module k_dsp_alu_mc #(
    parameter int WIDTH    = 32,
    parameter int SHIFT_LO = 8,
    parameter int SHIFT_HI = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    k_dsp_alu_mc_if.slave    io_bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DIV  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;
    logic             r_is_rem;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_flag_zero;
    logic             r_flag_carry;
    logic             r_flag_dbz;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_start_div;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_sc_result;
    logic             w_sc_carry;
    logic             w_sc_dbz;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_div_result;

    assign w_in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & io_bus.out_ready);
    assign w_accept    = io_bus.in_valid & w_in_ready;
    assign w_start_div = ((io_bus.op == 3'b100) | (io_bus.op == 3'b111)) &
                         (io_bus.op_b != {WIDTH{1'b0}});
    assign w_sum       = {1'b0, io_bus.op_a} + {1'b0, io_bus.op_b};

    // Single-cycle datapath; divide ops here only cover the divide-by-zero case.
    always_comb begin
        w_sc_result = {WIDTH{1'b0}};
        w_sc_carry  = 1'b0;
        w_sc_dbz    = 1'b0;
        case (io_bus.op)
            3'b000: begin
                w_sc_result = w_sum[WIDTH-1:0];
                w_sc_carry  = w_sum[WIDTH];
            end
            3'b001: w_sc_result = io_bus.op_a & io_bus.op_b;
            3'b010: w_sc_result = io_bus.op_b >> SHIFT_LO;
            3'b011: w_sc_result = io_bus.op_b >> SHIFT_HI;
            3'b100: begin
                w_sc_result = {WIDTH{1'b1}};
                w_sc_dbz    = (io_bus.op_b == {WIDTH{1'b0}});
            end
            3'b101: begin
                w_sc_result = io_bus.op_a - io_bus.op_b;
                w_sc_carry  = (io_bus.op_a < io_bus.op_b);
            end
            3'b110: w_sc_result = {{(WIDTH-1){1'b0}}, (io_bus.op_a == {WIDTH{1'b0}})};
            3'b111: begin
                w_sc_result = io_bus.op_a;
                w_sc_dbz    = (io_bus.op_b == {WIDTH{1'b0}});
            end
            default: begin
                w_sc_result = {WIDTH{1'b0}};
                w_sc_carry  = 1'b0;
                w_sc_dbz    = 1'b0;
            end
        endcase
    end

    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_divisor};

    // One restoring-division step: keep the trial difference only if it did not borrow.
    always_comb begin
        w_rem_next = w_shift[WIDTH-1:0];
        w_qbit     = 1'b0;
        if (!w_trial[WIDTH]) begin
            w_rem_next = w_trial[WIDTH-1:0];
            w_qbit     = 1'b1;
        end else begin
            w_rem_next = w_shift[WIDTH-1:0];
            w_qbit     = 1'b0;
        end
    end

    assign w_quot_next  = {r_quot[WIDTH-2:0], w_qbit};
    assign w_div_result = r_is_rem ? w_rem_next : w_quot_next;

    // Control FSM with the result/flag registers and divider state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rem        <= {WIDTH{1'b0}};
            r_quot       <= {WIDTH{1'b0}};
            r_divisor    <= {WIDTH{1'b0}};
            r_is_rem     <= 1'b0;
            r_count      <= {CW{1'b0}};
            r_result     <= {WIDTH{1'b0}};
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
            r_flag_dbz   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_start_div) begin
                            r_state     <= S_DIV;
                            r_rem       <= {WIDTH{1'b0}};
                            r_quot      <= io_bus.op_a;
                            r_divisor   <= io_bus.op_b;
                            r_is_rem    <= (io_bus.op == 3'b111);
                            r_count     <= CW'(WIDTH);
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state      <= S_DONE;
                            r_result     <= w_sc_result;
                            r_flag_zero  <= (w_sc_result == {WIDTH{1'b0}});
                            r_flag_carry <= w_sc_carry;
                            r_flag_dbz   <= w_sc_dbz;
                            r_out_valid  <= 1'b1;
                        end
                    end else if ((r_state == S_DONE) && io_bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_DIV: begin
                    r_rem   <= w_rem_next;
                    r_quot  <= w_quot_next;
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state      <= S_DONE;
                        r_result     <= w_div_result;
                        r_flag_zero  <= (w_div_result == {WIDTH{1'b0}});
                        r_flag_carry <= 1'b0;
                        r_flag_dbz   <= 1'b0;
                        r_out_valid  <= 1'b1;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.in_ready   = w_in_ready;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.result     = r_result;
    assign io_bus.flag_zero  = r_flag_zero;
    assign io_bus.flag_carry = r_flag_carry;
    assign io_bus.flag_dbz   = r_flag_dbz;
    assign io_bus.wr_en      = r_out_valid & io_bus.out_ready;

endmodule

// File: doc/k_dsp_alu_mc.md
Name: k_dsp_alu_mc

Overview:
Parametrised, handshaked, multi-cycle ALU for the K_DSP datapath, replacing the fixed 32-bit combinational ALU. It accepts one operation per valid/ready transfer, executes single-cycle ops in one clock and divide/remainder iteratively (one quotient bit per clock), then holds the result with status flags until the consumer accepts it. One operation is in flight at a time. A back-to-back accept is allowed on the same cycle a result is consumed.

Parameters:
WIDTH, 32, operand/result width; legal range 2..64.
SHIFT_LO, 8, shift amount for op 3'b010; must be < WIDTH.
SHIFT_HI, 16, shift amount for op 3'b011; must be < WIDTH.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  a command is presented on op/op_a/op_b.
in_ready  output  1  block can accept a command this cycle.
op  input  3  operation select.
op_a  input  WIDTH  operand A (unsigned).
op_b  input  WIDTH  operand B (unsigned).
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  operation result.
flag_zero  output  1  result == 0.
flag_carry  output  1  add carry-out, or sub borrow; 0 for all other ops.
flag_dbz  output  1  divide/remainder with op_b == 0.
wr_en  output  1  one-cycle pulse, equal to out_valid & out_ready (register-file write strobe).

Behaviour:
- Reset (async, rst_n low): state=IDLE; out_valid=0, result=0, all flags=0, wr_en=0, divider registers and counter=0. Reset mid-divide aborts the divide with no output.
- States: IDLE, DIV, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready); combinational. Accept = in_valid & in_ready; op/op_a/op_b are captured only on accept.
- Opcodes:
  - 000: a+b; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 001: a&b.
  - 010: b>>SHIFT_LO (logical).
  - 011: b>>SHIFT_HI (logical).
  - 100: a/b quotient (unsigned).
  - 101: a-b modulo 2^WIDTH; carry = borrow (a<b).
  - 110: zero test; result = {0…0, (a==0)}.
  - 111: a%b remainder (new).
- Non-divide ops (and divide with b==0): on accept, go to DONE; out_valid=1 the next cycle (latency 1).
- Divide/remainder with b!=0: on accept, go to DIV and load the restoring divider (rem=0, quotient=a, count=WIDTH). Each DIV cycle: shift {rem,quot} left 1, trial-subtract b, set the quotient LSB. After WIDTH cycles go to DONE. out_valid rises WIDTH+1 cycles after the accept cycle. result is the quotient (100) or remainder (111).
- Divide by zero: result = all ones for 100, result = a for 111; flag_dbz=1; latency 1.
- flag_zero is computed from the final result. All flags are registered alongside result.
- In DONE, result and flags stay stable while out_valid & !out_ready.
- DONE & out_ready & !in_valid: go to IDLE; out_valid=0 the next cycle.
- DONE & out_ready & in_valid: consume and accept in the same cycle. The next state is DONE (single-cycle op) or DIV. No bubble for single-cycle ops.
- In DIV, in_ready=0 and out_valid=0. in_valid is ignored and the command is held by the producer.
- result and flags after out_valid drops: they hold their last values (don't-care to consumers).
- No X propagation: op values are fully decoded.

Test Plan:
- Reset mid-divide: accept op=100 a=100 b=7, assert rst_n=0 at DIV cycle 5 -> out_valid=0, result=0, state IDLE immediately; after release, in_ready=1.
- Add carry, WIDTH=32: op=000 a=32'hFFFF_FFFF b=1 -> one cycle after accept: out_valid=1, result=0, flag_zero=1, flag_carry=1, wr_en pulses on out_ready.
- Sub borrow and shifts: op=101 a=3 b=5 -> result=32'hFFFF_FFFE, flag_carry=1. Then op=011 b=32'h1234_5678 -> result=32'h0000_1234.
- Divide latency: op=100 a=100 b=7 -> out_valid exactly 33 cycles after accept, result=14. Then op=111 with the same operands -> result=2.
- Divide by zero: op=100 a=9 b=0 -> latency 1, result=32'hFFFF_FFFF, flag_dbz=1. Then op=111 a=9 b=0 -> result=9, flag_dbz=1.
- Backpressure and back-to-back: hold out_ready=0 for 4 cycles -> result is stable and in_ready=0. Then assert out_ready with in_valid (op=001 a=F0 b=3C) -> wr_en pulses once, the new result 8'h30 is valid the next cycle, and no bubble occurs.
